// File: rtl/dual_issue_queue.sv
// Dual-width in-order issue buffer between decode and execute.
// Two tasks in, up to two hazard-free tasks out per cycle.
package dual_issue_queue_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef struct packed {
    logic [6:0] opcode;
    logic       rd_used;
    logic [4:0] rd_addr;
    logic       rs1_used;
    logic [4:0] rs1_addr;
    logic       rs2_used;
    logic [4:0] rs2_addr;
  } task_t;

endpackage

module dual_issue_queue
  import dual_issue_queue_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             FLUSH,
  input  logic             IN_VALID_0,
  input  logic             IN_VALID_1,
  input  task_t            TASK_0,
  input  task_t            TASK_1,
  output logic             IN_READY,
  output logic             OUT_VALID_0,
  output logic             OUT_VALID_1,
  output task_t            ISSUE_0,
  output task_t            ISSUE_1,
  input  logic             OUT_READY_0,
  input  logic             OUT_READY_1,
  output logic [CNT_W-1:0] COUNT
);

  localparam int PTR_W = $clog2(DEPTH);

  task_t            mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] head_p1;
  logic [PTR_W-1:0] tail_p1;
  logic [CNT_W-1:0] count;

  task_t i0;
  task_t i1;
  logic  raw;
  logic  waw;
  logic  mem_conf;
  logic  ctl;
  logic  hz;
  logic  push0;
  logic  push1;
  logic  pop0;
  logic  pop1;
  logic  [1:0] npush;
  logic  [1:0] npop;

  function automatic logic is_mem(logic [6:0] op);
    return (op == OPC_LOAD) || (op == OPC_STORE);
  endfunction

  function automatic logic is_ctl(logic [6:0] op);
    return (op == OPC_BRANCH) || (op == OPC_JAL) ||
           (op == OPC_JALR);
  endfunction

  assign head_p1 = head + PTR_W'(1);
  assign tail_p1 = tail + PTR_W'(1);
  assign i0      = mem[head];
  assign i1      = mem[head_p1];
  assign ISSUE_0 = i0;
  assign ISSUE_1 = i1;
  assign COUNT   = count;

  // Conservative: only registered count, never a same-cycle pop.
  assign IN_READY = count <= CNT_W'(DEPTH - 2);

  assign raw = i0.rd_used && (i0.rd_addr != 5'd0) &&
               ((i1.rs1_used && (i1.rs1_addr == i0.rd_addr)) ||
                (i1.rs2_used && (i1.rs2_addr == i0.rd_addr)));
  assign waw = i0.rd_used && i1.rd_used &&
               (i0.rd_addr != 5'd0) &&
               (i0.rd_addr == i1.rd_addr);
  assign mem_conf = is_mem(i0.opcode) && is_mem(i1.opcode);
  assign ctl      = is_ctl(i0.opcode);
  assign hz       = raw || waw || mem_conf || ctl;

  assign OUT_VALID_0 = count >= CNT_W'(1);
  assign OUT_VALID_1 = (count >= CNT_W'(2)) && !hz;

  assign push0 = IN_READY && IN_VALID_0;
  assign push1 = IN_READY && IN_VALID_1;
  assign pop0  = OUT_VALID_0 && OUT_READY_0;
  assign pop1  = OUT_VALID_1 && OUT_READY_1 && pop0;
  assign npush = {1'b0, push0} + {1'b0, push1};
  assign npop  = {1'b0, pop0} + {1'b0, pop1};

  always_ff @(posedge CLK) begin
    if (RST || FLUSH) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(npop);
      tail  <= tail + PTR_W'(npush);
      count <= count + CNT_W'(npush) - CNT_W'(npop);
    end
  end

  // Compacting write: a lone TASK_1 lands at tail.
  always_ff @(posedge CLK) begin
    if (!RST && !FLUSH) begin
      if (push0) mem[tail] <= TASK_0;
      if (push1) mem[push0 ? tail_p1 : tail] <= TASK_1;
    end
  end

  a_count_bound : assert property (
    @(posedge CLK) disable iff (RST)
    count <= CNT_W'(DEPTH));

  a_pop_order : assert property (
    @(posedge CLK) disable iff (RST)
    pop1 |-> pop0);

endmodule

// File: tb/tb_dual_issue_queue.sv
// Directed vector bench for dual_issue_queue.
// Table vectors plus a randomized-ready streaming scoreboard.
module tb_dual_issue_queue;
  import dual_issue_queue_pkg::*;

  logic       CLK;
  logic       RST;
  logic       FLUSH;
  logic       IN_VALID_0;
  logic       IN_VALID_1;
  task_t      TASK_0;
  task_t      TASK_1;
  logic       IN_READY;
  logic       OUT_VALID_0;
  logic       OUT_VALID_1;
  task_t      ISSUE_0;
  task_t      ISSUE_1;
  logic       OUT_READY_0;
  logic       OUT_READY_1;
  logic [3:0] COUNT;

  int n_cmp;
  int n_bad;

  dual_issue_queue #(.DEPTH(8)) dut (
    .CLK(CLK),
    .RST(RST),
    .FLUSH(FLUSH),
    .IN_VALID_0(IN_VALID_0),
    .IN_VALID_1(IN_VALID_1),
    .TASK_0(TASK_0),
    .TASK_1(TASK_1),
    .IN_READY(IN_READY),
    .OUT_VALID_0(OUT_VALID_0),
    .OUT_VALID_1(OUT_VALID_1),
    .ISSUE_0(ISSUE_0),
    .ISSUE_1(ISSUE_1),
    .OUT_READY_0(OUT_READY_0),
    .OUT_READY_1(OUT_READY_1),
    .COUNT(COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic  rst;
    logic  flush;
    logic  v0;
    logic  v1;
    task_t t0;
    task_t t1;
    logic  r0;
    logic  r1;
    int    cnt;
    int    ov0;
    int    ov1;
    int    ir;
    int    i0;
    int    i1;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs [NV];

  function automatic task_t mk(logic [6:0] op,
                               logic du, int rd,
                               logic u1, int a,
                               logic u2, int b);
    task_t t;
    t.opcode   = op;
    t.rd_used  = du;
    t.rd_addr  = 5'(rd);
    t.rs1_used = u1;
    t.rs1_addr = 5'(a);
    t.rs2_used = u2;
    t.rs2_addr = 5'(b);
    return t;
  endfunction

  function automatic task_t addi(int rd, int a);
    return mk(OPC_OP_IMM, 1'b1, rd, 1'b1, a, 1'b0, 0);
  endfunction

  function automatic task_t alu(int rd, int a, int b);
    return mk(OPC_OP, 1'b1, rd, 1'b1, a, 1'b1, b);
  endfunction

  function automatic task_t lw(int rd, int a);
    return mk(OPC_LOAD, 1'b1, rd, 1'b1, a, 1'b0, 0);
  endfunction

  function automatic task_t sw(int src, int a);
    return mk(OPC_STORE, 1'b0, 0, 1'b1, a, 1'b1, src);
  endfunction

  function automatic task_t beq(int a, int b);
    return mk(OPC_BRANCH, 1'b0, 0, 1'b1, a, 1'b1, b);
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic idle();
    RST         = 1'b0;
    FLUSH       = 1'b0;
    IN_VALID_0  = 1'b0;
    IN_VALID_1  = 1'b0;
    TASK_0      = '0;
    TASK_1      = '0;
    OUT_READY_0 = 1'b0;
    OUT_READY_1 = 1'b0;
  endtask

  task automatic apply(int k);
    vec_t v;
    v           = vecs[k];
    RST         = v.rst;
    FLUSH       = v.flush;
    IN_VALID_0  = v.v0;
    IN_VALID_1  = v.v1;
    TASK_0      = v.t0;
    TASK_1      = v.t1;
    OUT_READY_0 = v.r0;
    OUT_READY_1 = v.r1;
    @(posedge CLK);
    #1;
    chk($sformatf("v%0d count", k), int'(COUNT), v.cnt);
    chk($sformatf("v%0d ov0", k), int'(OUT_VALID_0), v.ov0);
    chk($sformatf("v%0d ov1", k), int'(OUT_VALID_1), v.ov1);
    chk($sformatf("v%0d ready", k), int'(IN_READY), v.ir);
    if (v.i0 >= 0)
      chk($sformatf("v%0d i0.rd", k),
          int'(ISSUE_0.rd_addr), v.i0);
    if (v.i1 >= 0)
      chk($sformatf("v%0d i1.rd", k),
          int'(ISSUE_1.rd_addr), v.i1);
  endtask

  int q[$];
  int sent;
  int got;
  int ta;
  int tb;
  logic p0;
  logic p1;
  logic do_push;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    idle();
    // rst flush v0 v1 t0 t1 r0 r1 | cnt ov0 ov1 ir i0 i1
    vecs[0]  = '{1,0,1,1,addi(1,0),addi(2,0),0,0, 0,0,0,1,-1,-1};
    vecs[1]  = '{0,0,1,1,addi(1,0),addi(2,0),0,0, 2,1,1,1, 1, 2};
    vecs[2]  = '{0,0,1,1,addi(3,0),addi(4,0),0,0, 4,1,1,1, 1, 2};
    vecs[3]  = '{0,0,1,1,addi(5,0),addi(6,0),0,0, 6,1,1,1, 1, 2};
    vecs[4]  = '{0,0,1,0,addi(7,0),addi(9,0),0,0, 7,1,1,0, 1, 2};
    vecs[5]  = '{0,0,1,1,addi(8,0),addi(9,0),0,0, 7,1,1,0, 1, 2};
    vecs[6]  = '{0,1,1,1,addi(8,0),addi(9,0),1,0, 0,0,0,1,-1,-1};
    vecs[7]  = '{0,0,1,1,addi(1,0),addi(2,0),1,1, 2,1,1,1, 1, 2};
    vecs[8]  = '{0,0,0,0,'0,'0,1,1,               0,0,0,1,-1,-1};
    vecs[9]  = '{0,0,1,1,alu(3,1,2),alu(4,3,5),0,0, 2,1,0,1, 3, 4};
    vecs[10] = '{0,0,0,0,'0,'0,1,1,               1,1,0,1, 4,-1};
    vecs[11] = '{0,0,0,0,'0,'0,1,0,               0,0,0,1,-1,-1};
    vecs[12] = '{0,0,1,1,alu(0,1,2),alu(4,0,5),0,0, 2,1,1,1, 0, 4};
    vecs[13] = '{0,0,0,0,'0,'0,1,1,               0,0,0,1,-1,-1};
    vecs[14] = '{0,0,1,1,lw(6,1),sw(7,2),0,0,     2,1,0,1, 6,-1};
    vecs[15] = '{0,0,0,0,'0,'0,1,1,               1,1,0,1,-1,-1};
    vecs[16] = '{0,0,0,0,'0,'0,1,0,               0,0,0,1,-1,-1};
    vecs[17] = '{0,0,1,1,beq(1,2),addi(8,0),0,0,  2,1,0,1,-1, 8};
    vecs[18] = '{0,0,0,0,'0,'0,1,1,               1,1,0,1, 8,-1};
    vecs[19] = '{0,0,0,0,'0,'0,1,0,               0,0,0,1,-1,-1};
    vecs[20] = '{0,0,1,1,addi(10,0),addi(11,0),0,0, 2,1,1,1,10,11};
    vecs[21] = '{0,0,1,1,addi(12,0),addi(13,0),0,0, 4,1,1,1,10,11};
    vecs[22] = '{0,0,1,0,addi(14,0),addi(9,0),0,0,  5,1,1,1,10,11};
    vecs[23] = '{0,1,1,1,addi(15,0),addi(16,0),1,1, 0,0,0,1,-1,-1};
    vecs[24] = '{0,0,1,1,addi(20,0),addi(21,0),0,0, 2,1,1,1,20,21};
    vecs[25] = '{0,0,0,1,addi(9,0),addi(22,0),0,0,  3,1,1,1,20,21};
    vecs[26] = '{0,0,0,0,'0,'0,1,1,               1,1,0,1,22,-1};
    vecs[27] = '{0,0,0,0,'0,'0,1,0,               0,0,0,1,-1,-1};

    #2;
    for (int k = 0; k < NV; k++) apply(k);

    idle();
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 400 && got < 40; cyc++) begin
      chk("st count", int'(COUNT), q.size());
      chk("st bound", int'(COUNT <= 4'd8), 1);
      chk("st ov0", int'(OUT_VALID_0), int'(q.size() >= 1));
      chk("st ov1", int'(OUT_VALID_1), int'(q.size() >= 2));
      if (q.size() >= 1)
        chk("st i0", int'(ISSUE_0.rd_addr), q[0]);
      if (q.size() >= 2)
        chk("st i1", int'(ISSUE_1.rd_addr), q[1]);
      OUT_READY_0 = 1'($urandom_range(0, 1));
      OUT_READY_1 = 1'($urandom_range(0, 1));
      do_push = (sent < 20) && (q.size() <= 6);
      ta = (2 * sent) % 31 + 1;
      tb = (2 * sent + 1) % 31 + 1;
      IN_VALID_0 = do_push;
      IN_VALID_1 = do_push;
      TASK_0 = addi(ta, 0);
      TASK_1 = addi(tb, 0);
      p0 = (q.size() >= 1) && OUT_READY_0;
      p1 = p0 && OUT_READY_1 && (q.size() >= 2);
      @(posedge CLK);
      #1;
      if (p0) begin void'(q.pop_front()); got++; end
      if (p1) begin void'(q.pop_front()); got++; end
      if (do_push) begin
        q.push_back(ta);
        q.push_back(tb);
        sent++;
      end
    end
    chk("st drained", got, 40);
    chk("st final count", int'(COUNT), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
